// File: rtl/bias_add.sv
// bias_add: per-group signed bias addition with saturation, 4-slot input FIFO and a 2-stage pipeline.
// Define BIAS_ADD_RELU_EN to clamp negative results to zero in the second stage.
module bias_add #(
  parameter int DATA_WIDTH      = 8,
  parameter int GROUP_SIZE      = 4,
  parameter int NUM_ADDRESSES   = 4096,
  parameter int LOG_MAX_ADDRESS = 12,
  parameter int LOG_MAX_OUTPUTS = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ADDRESS-1:0]       num_bias,
  input  logic [LOG_MAX_OUTPUTS-1:0]       num_outputs,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] bias_in,
  input  logic                             bias_valid,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic                             busy
);

  localparam int WORD_W = GROUP_SIZE * DATA_WIDTH;
  localparam int SUM_W  = DATA_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [LOG_MAX_ADDRESS-1:0] ADDR_ONE = {{(LOG_MAX_ADDRESS-1){1'b0}}, 1'b1};
  localparam logic [LOG_MAX_OUTPUTS-1:0] OUT_ONE  = {{(LOG_MAX_OUTPUTS-1){1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic [SUM_W-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    if (s[SUM_W-1] != s[SUM_W-2]) begin
      r = s[SUM_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      r = s[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
`ifdef BIAS_ADD_RELU_EN
    return x[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : x;
`else
    return x;
`endif
  endfunction

  logic [1:0]                 state_r, state_nx_s;
  logic [LOG_MAX_ADDRESS-1:0] num_bias_r, load_cnt_r, bias_addr_r;
  logic [LOG_MAX_OUTPUTS-1:0] num_outputs_r, out_cnt_r;
  logic [WORD_W-1:0]          fifo_mem_r [4];
  logic [1:0]                 wr_ptr_r, rd_ptr_r;
  logic [2:0]                 fifo_cnt_r, fifo_cnt_nx_s;
  logic                       avail_out_r;
  logic [WORD_W-1:0]          bias_mem_r [NUM_ADDRESSES];
  logic [SUM_W-1:0]           sum_s  [GROUP_SIZE];
  logic [SUM_W-1:0]           sum1_r [GROUP_SIZE];
  logic                       v1_r, v2_r;
  logic [WORD_W-1:0]          result_s, d2_r;
  logic [WORD_W-1:0]          head_s, bias_word_s;
  logic                       fifo_empty_s, fifo_full_s, fifo_wr_s;
  logic                       cfg_ok_s, abort_s, consume_s, bias_wr_s;
  logic                       last_bias_s, last_out_s, addr_wrap_s;

  assign fifo_empty_s = (fifo_cnt_r == 3'd0);
  assign fifo_full_s  = (fifo_cnt_r == 3'd4);
  assign fifo_wr_s    = valid_in & ~fifo_full_s;
  assign cfg_ok_s     = (num_bias != {LOG_MAX_ADDRESS{1'b0}}) & (num_outputs != {LOG_MAX_OUTPUTS{1'b0}});
  // A configure during a job has priority over any bias write or consume in the same cycle.
  assign abort_s      = configure & (state_r != IDLE);
  assign consume_s    = (state_r == RUN) & ~configure & ~fifo_empty_s & avail_in;
  assign bias_wr_s    = (state_r == LOAD) & ~configure & bias_valid;
  assign last_bias_s  = (load_cnt_r == num_bias_r - ADDR_ONE);
  assign last_out_s   = (out_cnt_r == num_outputs_r - OUT_ONE);
  assign addr_wrap_s  = (bias_addr_r == num_bias_r - ADDR_ONE);
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign bias_word_s  = bias_mem_r[bias_addr_r];

  // Next-state and FIFO occupancy logic.
  always_comb begin
    state_nx_s    = state_r;
    fifo_cnt_nx_s = fifo_cnt_r;
    case (state_r)
      IDLE: begin
        if (configure && cfg_ok_s) state_nx_s = LOAD;
        else                       state_nx_s = IDLE;
      end
      LOAD: begin
        if (configure)                      state_nx_s = cfg_ok_s ? LOAD : IDLE;
        else if (bias_wr_s && last_bias_s)  state_nx_s = RUN;
        else                                state_nx_s = LOAD;
      end
      RUN: begin
        if (configure)                      state_nx_s = cfg_ok_s ? LOAD : IDLE;
        else if (consume_s && last_out_s)   state_nx_s = IDLE;
        else                                state_nx_s = RUN;
      end
      default: state_nx_s = IDLE;
    endcase
    if (fifo_wr_s && !consume_s)      fifo_cnt_nx_s = fifo_cnt_r + 3'd1;
    else if (!fifo_wr_s && consume_s) fifo_cnt_nx_s = fifo_cnt_r - 3'd1;
    else                              fifo_cnt_nx_s = fifo_cnt_r;
  end

  // Job state, sampled job sizes and load/consume counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      num_bias_r    <= {LOG_MAX_ADDRESS{1'b0}};
      num_outputs_r <= {LOG_MAX_OUTPUTS{1'b0}};
      load_cnt_r    <= {LOG_MAX_ADDRESS{1'b0}};
      bias_addr_r   <= {LOG_MAX_ADDRESS{1'b0}};
      out_cnt_r     <= {LOG_MAX_OUTPUTS{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (configure) begin
        num_bias_r    <= num_bias;
        num_outputs_r <= num_outputs;
        load_cnt_r    <= {LOG_MAX_ADDRESS{1'b0}};
        bias_addr_r   <= {LOG_MAX_ADDRESS{1'b0}};
        out_cnt_r     <= {LOG_MAX_OUTPUTS{1'b0}};
      end else begin
        if (bias_wr_s) load_cnt_r <= load_cnt_r + ADDR_ONE;
        if (consume_s) begin
          out_cnt_r   <= out_cnt_r + OUT_ONE;
          bias_addr_r <= addr_wrap_s ? {LOG_MAX_ADDRESS{1'b0}} : bias_addr_r + ADDR_ONE;
        end
      end
    end
  end

  // FIFO pointers, occupancy and the upstream ready flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      fifo_cnt_r  <= 3'd0;
      avail_out_r <= 1'b1;
    end else begin
      if (fifo_wr_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (consume_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      fifo_cnt_r  <= fifo_cnt_nx_s;
      avail_out_r <= (fifo_cnt_nx_s < 3'd3);
    end
  end

  // FIFO and bias storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (fifo_wr_s) fifo_mem_r[wr_ptr_r] <= data_in;
    if (bias_wr_s) bias_mem_r[load_cnt_r] <= bias_in;
  end

  // Stage 1 adder: sign-extended item plus bias at DATA_WIDTH+1 bits.
  always_comb begin
    for (int g = 0; g < GROUP_SIZE; g++) begin
      sum_s[g] = {head_s[g*DATA_WIDTH + DATA_WIDTH - 1], head_s[g*DATA_WIDTH +: DATA_WIDTH]}
               + {bias_word_s[g*DATA_WIDTH + DATA_WIDTH - 1], bias_word_s[g*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Stage 2 saturation and optional ReLU.
  always_comb begin
    result_s = {WORD_W{1'b0}};
    for (int g = 0; g < GROUP_SIZE; g++) begin
      result_s[g*DATA_WIDTH +: DATA_WIDTH] = relu(saturate(sum1_r[g]));
    end
  end

  // Two-stage pipeline registers; an abort drops both in-flight valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      d2_r <= {WORD_W{1'b0}};
      for (int g = 0; g < GROUP_SIZE; g++) sum1_r[g] <= {SUM_W{1'b0}};
    end else begin
      v1_r <= consume_s;
      v2_r <= v1_r & ~abort_s;
      if (consume_s) begin
        for (int g = 0; g < GROUP_SIZE; g++) sum1_r[g] <= sum_s[g];
      end
      if (v1_r) d2_r <= result_s;
    end
  end

  assign avail_out = avail_out_r;
  assign valid_out = v2_r;
  assign data_out  = d2_r;
  assign busy      = (state_r != IDLE) | v1_r | v2_r;

endmodule

// File: tb/tb_bias_add.sv
// Self-checking bench for bias_add: directed job sequence with random data and biases,
// results compared against a saturating-arithmetic reference model.
module tb_bias_add;
  localparam int DW = 8;
  localparam int GS = 4;
  localparam int W  = DW * GS;

  logic          clk;
  logic          rst;
  logic          configure;
  logic [11:0]   num_bias;
  logic [23:0]   num_outputs;
  logic [W-1:0]  bias_in;
  logic          bias_valid;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          avail_out;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          avail_in;
  logic          busy;

  bias_add dut (
    .clk(clk), .rst(rst), .configure(configure), .num_bias(num_bias),
    .num_outputs(num_outputs), .bias_in(bias_in), .bias_valid(bias_valid),
    .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
    .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_seen = 0;
  int nb_m = 1;
  int k_m = 0;
  logic [W-1:0] bias_m [16];
  logic [W-1:0] exp_q [$];

  // Reference: per-item signed add, clamp to the DW-bit range, optional ReLU.
  function automatic logic [W-1:0] ref_group(input logic [W-1:0] d, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic signed [DW-1:0] a, c;
    int s;
    int hi = (2 ** (DW - 1)) - 1;
    int lo = -(2 ** (DW - 1));
    r = '0;
    for (int i = 0; i < GS; i++) begin
      a = d[i*DW +: DW];
      c = b[i*DW +: DW];
      s = int'(a) + int'(c);
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`ifdef BIAS_ADD_RELU_EN
      if (s < 0) s = 0;
`endif
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_config(input int nb, input int no);
    configure   = 1'b1;
    num_bias    = 12'(nb);
    num_outputs = 24'(no);
    cyc();
    configure   = 1'b0;
    if (nb != 0 && no != 0) begin
      nb_m = nb;
      k_m  = 0;
    end
  endtask

  task automatic do_bias(input int idx, input logic [W-1:0] w);
    bias_in     = w;
    bias_valid  = 1'b1;
    bias_m[idx] = w;
    cyc();
    bias_valid  = 1'b0;
  endtask

  task automatic send_exp(input logic [W-1:0] d, input logic [W-1:0] e);
    int budget = 50;
    while (avail_out !== 1'b1 && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) timeout_fail("avail_out_wait");
    data_in  = d;
    valid_in = 1'b1;
    exp_q.push_back(e);
    k_m++;
    cyc();
    valid_in = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] d;
    d = $urandom;
    send_exp(d, ref_group(d, bias_m[k_m % nb_m]));
  endtask

  task automatic wait_out(input int n);
    int budget = 200;
    while (out_seen < n && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) timeout_fail("wait_valid_out");
  endtask

  // Output monitor: every valid_out must match the oldest outstanding expected result.
  always begin
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_valid_out: observed data_out %h expected no result", data_out);
      end else begin
        chk_word("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int fall_base;
    int mid_cnt;
    logic [W-1:0] w;

    rst = 1'b0; configure = 1'b0; num_bias = 12'd0; num_outputs = 24'd0;
    bias_in = '0; bias_valid = 1'b0; data_in = '0; valid_in = 1'b0; avail_in = 1'b1;
    repeat (3) cyc();
    chk_bit("rst_valid_out", valid_out, 1'b0);
    chk_word("rst_data_out", data_out, '0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_avail_out", avail_out, 1'b1);
    rst = 1'b1;
    cyc();

    // Basic job with fixed values and latency check.
    base = out_seen;
    do_config(2, 4);
    chk_bit("load_busy", busy, 1'b1);
    do_bias(0, 32'h01020304);
    do_bias(1, 32'h0A0A0A0A);
    send_exp(32'h10101010, 32'h11121314);
    chk_bit("lat_c1", valid_out, 1'b0);
    cyc();
    chk_bit("lat_c2", valid_out, 1'b0);
    cyc();
    chk_bit("lat_c3", valid_out, 1'b1);
    send_exp(32'h10101010, 32'h1A1A1A1A);
    send_exp(32'h10101010, 32'h11121314);
    send_exp(32'h10101010, 32'h1A1A1A1A);
    wait_out(base + 4);
    chk_bit("basic_busy_last", busy, 1'b1);
    cyc();
    chk_bit("basic_busy_after", busy, 1'b0);
    chk_int("basic_count", out_seen - base, 4);

    // Saturation and ReLU corner items.
    base = out_seen;
    do_config(2, 2);
    do_bias(0, 32'h01FF05FF);
    w = $urandom;
    do_bias(1, w);
`ifdef BIAS_ADD_RELU_EN
    send_exp(32'hF0807F80, 32'h00007F00);
`else
    send_exp(32'hF0807F80, 32'hF1807F80);
`endif
    send_rand();
    wait_out(base + 2);
    cyc();
    chk_bit("sat_busy_after", busy, 1'b0);

    // Backpressure: avail_in low for 10 cycles mid-stream.
    base = out_seen;
    do_config(3, 12);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      do_bias(i, w);
    end
    repeat (4) send_rand();
    avail_in = 1'b0;
    fall_base = out_seen;
    send_rand();
    send_rand();
    mid_cnt = out_seen;
    chk_bit("bp_avail_out_at3", avail_out, 1'b0);
    repeat (8) cyc();
    chk_bit("bp_at_most_2", (out_seen - fall_base) <= 2, 1'b1);
    chk_int("bp_no_more_out", out_seen, mid_cnt);
    chk_bit("bp_avail_out_held", avail_out, 1'b0);
    avail_in = 1'b1;
    repeat (6) send_rand();
    wait_out(base + 12);
    cyc();
    chk_int("bp_count", out_seen - base, 12);
    chk_bit("bp_busy_after", busy, 1'b0);

    // Abort in RUN after 3 of 8 outputs.
    base = out_seen;
    do_config(2, 8);
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      do_bias(i, w);
    end
    repeat (4) send_rand();
    wait_out(base + 3);
    exp_q.delete();
    do_config(1, 2);
    chk_bit("abort_busy_load", busy, 1'b1);
    chk_bit("abort_valid_out", valid_out, 1'b0);
    repeat (4) cyc();
    chk_int("abort_no_old_out", out_seen, base + 3);
    w = $urandom;
    do_bias(0, w);
    send_rand();
    send_rand();
    wait_out(base + 5);
    cyc();
    chk_bit("abort_busy_after", busy, 1'b0);

    // Reset in RUN discards everything in flight.
    base = out_seen;
    do_config(1, 8);
    w = $urandom;
    do_bias(0, w);
    repeat (4) send_rand();
    wait_out(base + 2);
    rst = 1'b0;
    exp_q.delete();
    cyc();
    chk_bit("midrst_valid_out", valid_out, 1'b0);
    chk_word("midrst_data_out", data_out, '0);
    chk_bit("midrst_busy", busy, 1'b0);
    chk_bit("midrst_avail_out", avail_out, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    do_config(1, 2);
    w = $urandom;
    do_bias(0, w);
    repeat (6) cyc();
    chk_int("midrst_fifo_empty", out_seen, base + 2);
    chk_bit("midrst_run_waiting", busy, 1'b1);
    send_rand();
    send_rand();
    wait_out(base + 4);
    cyc();
    chk_bit("midrst_busy_after", busy, 1'b0);

    // Degenerate configures never start a job.
    base = out_seen;
    do_config(0, 5);
    chk_bit("degen_nb0_busy", busy, 1'b0);
    do_config(3, 0);
    chk_bit("degen_no0_busy", busy, 1'b0);
    bias_in = $urandom;
    bias_valid = 1'b1;
    data_in = $urandom;
    valid_in = 1'b1;
    repeat (2) cyc();
    bias_valid = 1'b0;
    valid_in = 1'b0;
    repeat (6) cyc();
    chk_int("degen_no_out", out_seen, base);
    chk_bit("degen_busy_end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bias_add.md
BIAS_ADD -- requirements
Module: bias_add

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8: signed width of one item, input and output.
REQ-002 The module SHALL have parameter GROUP_SIZE, default 4: items per group/word.
REQ-003 The module SHALL have parameter NUM_ADDRESSES, default 4096: bias memory depth, in groups.
REQ-004 The module SHALL have parameter LOG_MAX_ADDRESS, default 12: bias address and num_bias width.
REQ-005 The module SHALL have parameter LOG_MAX_OUTPUTS, default 24: num_outputs width.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 The module SHALL have port configure, input, 1 bit: starts a new job.
REQ-009 The module SHALL have port num_bias, input, LOG_MAX_ADDRESS bits: bias words per period, sampled on configure.
REQ-010 The module SHALL have port num_outputs, input, LOG_MAX_OUTPUTS bits: groups to process in the job, sampled on configure.
REQ-011 The module SHALL have port bias_in, input, GROUP_SIZE*DATA_WIDTH bits: bias word.
REQ-012 The module SHALL have port bias_valid, input, 1 bit: bias_in is valid.
REQ-013 The module SHALL have port data_in, input, GROUP_SIZE*DATA_WIDTH bits: accumulated group from the upstream ACC.
REQ-014 The module SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-015 The module SHALL have port avail_out, output, 1 bit: upstream may send.
REQ-016 The module SHALL have port data_out, output, GROUP_SIZE*DATA_WIDTH bits: result group.
REQ-017 The module SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-018 The module SHALL have port avail_in, input, 1 bit: downstream can accept.
REQ-019 The module SHALL have port busy, output, 1 bit: high when state is not IDLE or the pipeline holds a valid.

Function
REQ-020 Input SHALL be buffered in a 4-slot FIFO written on valid_in; avail_out = ~full & ~almost_full; writes while full are dropped.
REQ-021 The module SHALL implement states IDLE, LOAD and RUN.
REQ-022 IDLE -> LOAD on configure when num_bias != 0 and num_outputs != 0; otherwise configure leaves the FSM in IDLE.
REQ-023 In LOAD, each bias_valid SHALL write bias_in to address k (k = 0,1,...); after num_bias writes -> RUN; bias_valid outside LOAD is ignored.
REQ-024 In RUN, a group SHALL be consumed in a cycle iff FIFO not empty & avail_in.
REQ-025 The k-th consumed group SHALL use bias address k mod num_bias; the address counter wraps from num_bias-1 to 0.
REQ-026 Per item: sum = signed(data) + signed(bias), computed at DATA_WIDTH+1 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 Latency SHALL be exactly 2 cycles from consume to valid_out (stage 1: bias read + add; stage 2: saturate/ReLU register); valid_out is a 1-cycle pulse per group.
REQ-028 Downstream SHALL tolerate up to 2 valids after avail_in falls; the pipeline never stalls and output order equals input order.
REQ-029 After num_outputs groups have been consumed -> IDLE; in-flight results still emerge, and busy falls the cycle after the last valid_out.
REQ-030 configure in LOAD or RUN SHALL abort the job: both pipeline valids are cleared the next cycle, FIFO contents are kept, counters are reloaded and the FSM enters LOAD.

Reset
REQ-031 While rst = 0 at a clock edge: state = IDLE, FIFO empty, all counters = 0, pipeline valids = 0.
REQ-032 During reset, valid_out = 0, data_out = 0, busy = 0 and avail_out = 1 (the latter from the cycle after reset).
REQ-033 Bias memory contents SHALL NOT be reset.
REQ-034 Reset mid-job SHALL discard all in-flight data; no valid_out is produced afterwards until a new configure.

Configuration
REQ-035 Macro BIAS_ADD_RELU_EN defined: every saturated item that is negative SHALL be output as 0 (ReLU) in stage 2.
REQ-036 Macro BIAS_ADD_RELU_EN undefined: saturated items SHALL be output unchanged; there is no extra latency in either case.

Verification
REQ-037 Basic: num_bias=2, biases 0x01020304, 0x0A0A0A0A; inputs 4 x 0x10101010 -> outputs 0x11121314, 0x1A1A1A1A, 0x11121314, 0x1A1A1A1A, each 2 cycles after consume; then IDLE and busy low.
REQ-038 Saturation: item 0x7F + bias 0x05 -> 0x7F; item 0x80 + bias 0xFF -> 0x80 (macro off); item 0x80 + bias 0xFF -> 0x00 (macro on).
REQ-039 ReLU: item 0xF0 + bias 0x01 -> 0x00 with BIAS_ADD_RELU_EN, 0xF1 without.
REQ-040 Backpressure: avail_in low for 10 cycles mid-stream -> at most 2 valid_out after the fall, none after that until avail_in returns; full sequence complete and in order; avail_out low while FIFO holds 3 or more.
REQ-041 Abort/reset: configure in RUN after 3 of 8 outputs -> no further results from the old job, LOAD re-entered; rst low in RUN -> valid_out = 0 next cycle, busy = 0, FIFO empty.
REQ-042 Degenerate: configure with num_bias=0 or num_outputs=0 -> stays IDLE, no valid_out, bias_valid ignored.
